// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state encoding and direction constants for the counter control stage
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        HOLD = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise a raw button, accept a level only after it has been stable, pulse on presses
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    // two-flop synchroniser, then the level follows sync2 once it has disagreed for DEBOUNCE_CYCLES clocks in a row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: button-driven run/hold FSM producing direction and enable for an up/down counter, with optional limit bounce
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIDTH           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_stop,
    input  logic             auto_bounce,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] lo_limit,
    input  logic [WIDTH-1:0] hi_limit,
    output logic             direction,
    output logic             enable,
    output logic [1:0]       state_out
);

    state_t state;
    state_t nxt;
    logic   up_p;
    logic   down_p;
    logic   stop_p;
    logic   mem_up;
    logic   running;
    logic   bounce_en;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn_raw(btn_up), .level(), .press(up_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn_raw(btn_down), .level(), .press(down_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .rst(rst), .btn_raw(btn_stop), .level(), .press(stop_p)
    );

    assign running   = state == UP || state == DOWN;
    assign bounce_en = auto_bounce && lo_limit < hi_limit;
    assign state_out = state;

    // next state: stop beats down beats up; limits are only consulted when no button event is present
    always_comb begin
        nxt = state;
        if (stop_p)
            nxt = running ? HOLD : state == HOLD ? (mem_up ? UP : DOWN) : IDLE;
        else if (down_p)
            nxt = DOWN;
        else if (up_p)
            nxt = UP;
        else if (bounce_en && state == UP && count_in >= hi_limit)
            nxt = DOWN;
        else if (bounce_en && state == DOWN && count_in <= lo_limit)
            nxt = UP;
    end

    // state plus registered Moore outputs; HOLD keeps the last direction, and pausing remembers which run state to resume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_up    <= 1'b1;
            enable    <= 1'b0;
            direction <= DIR_UP;
        end else begin
            state     <= nxt;
            enable    <= nxt == UP || nxt == DOWN;
            direction <= nxt == DOWN ? DIR_DOWN : nxt == HOLD ? direction : DIR_UP;
            if (stop_p && running)
                mem_up <= state == UP;
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed vector table plus hand sequences for latency, reset and priority corners
module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_stop = 1'b0;
    logic       auto_bounce = 1'b0;
    logic [7:0] count_in = 8'd0;
    logic [7:0] lo_limit = 8'd10;
    logic [7:0] hi_limit = 8'd20;
    logic       direction;
    logic       enable;
    logic [1:0] state_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       up;
        logic       down;
        logic       stop;
        logic       ab;
        logic [7:0] cnt;
        logic [7:0] lo;
        logic [7:0] hi;
        int         n;
        logic [1:0] st;
        logic       en;
        logic       dir;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    count_ctrl #(.DEBOUNCE_CYCLES(4), .WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_stop(btn_stop),
        .auto_bounce(auto_bounce),
        .count_in(count_in),
        .lo_limit(lo_limit),
        .hi_limit(hi_limit),
        .direction(direction),
        .enable(enable),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] st, input logic en, input logic dir);
        total++;
        if ({state_out, enable, direction} !== {st, en, dir}) begin
            bad++;
            $display("FAIL %s: got state=%b en=%b dir=%b, want state=%b en=%b dir=%b",
                     name, state_out, enable, direction, st, en, dir);
        end
    endtask

    task automatic btns(input logic u, input logic d, input logic s);
        btn_up = u;
        btn_down = d;
        btn_stop = s;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        chk("reset_async", 2'b00, 1'b0, 1'b1);
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        // button held through reset, outputs checked before any clock edge
        btn_up = 1'b1;
        #2 rst = 1'b0;
        #1 chk("por_no_clock", 2'b00, 1'b0, 1'b1);
        step(3);
        rst = 1'b1;
        step(6);
        chk("held_rel_e6", 2'b00, 1'b0, 1'b1);
        step(1);
        chk("held_rel_e7", 2'b01, 1'b1, 1'b1);
        btns(0, 0, 0);
        step(10);

        // exact press latency from IDLE, then a short down glitch
        reset_pulse();
        btn_up = 1'b1;
        step(6);
        chk("up_e6", 2'b00, 1'b0, 1'b1);
        step(1);
        chk("up_e7", 2'b01, 1'b1, 1'b1);
        step(3);
        btn_up = 1'b0;
        btn_down = 1'b1;
        step(3);
        btn_down = 1'b0;
        step(10);
        chk("down_glitch", 2'b01, 1'b1, 1'b1);

        // from UP: stop/resume, bounce on limits, disabled bounce corners
        //           up    down  stop  ab    cnt     lo      hi      n   st     en    dir
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd10,  8'd20,  8,  2'b11, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd10,  8'd20,  10, 2'b11, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd10,  8'd20,  8,  2'b01, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd10,  8'd20,  10, 2'b01, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd18,  8'd10,  8'd20,  1,  2'b01, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd19,  8'd10,  8'd20,  1,  2'b01, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd20,  8'd10,  8'd20,  1,  2'b10, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd15,  8'd10,  8'd20,  1,  2'b10, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd11,  8'd10,  8'd20,  1,  2'b10, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd10,  8'd10,  8'd20,  1,  2'b01, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd12,  8'd10,  8'd20,  1,  2'b01, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd25,  8'd20,  8'd10,  3,  2'b01, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25,  8'd20,  8'd10,  8,  2'b10, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   8'd20,  8'd10,  10, 2'b10, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   8'd10,  8'd10,  3,  2'b10, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd5,   8'd10,  8'd20,  3,  2'b10, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   8'd10,  8'd20,  1,  2'b01, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'd10,  8'd20,  3,  2'b01, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd10,  8'd20,  3,  2'b01, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd10,  8'd20,  1,  2'b10, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd10,  8'd20,  8,  2'b11, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd10,  8'd20,  10, 2'b11, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd100, 8'd10,  8'd20,  8,  2'b10, 1'b1, 1'b0};
        for (int i = 0; i < NV; i++) begin
            btns(vecs[i].up, vecs[i].down, vecs[i].stop);
            auto_bounce = vecs[i].ab;
            count_in = vecs[i].cnt;
            lo_limit = vecs[i].lo;
            hi_limit = vecs[i].hi;
            step(vecs[i].n);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].dir);
        end
        btns(0, 0, 0);
        auto_bounce = 1'b0;
        count_in = 8'd0;
        lo_limit = 8'd10;
        hi_limit = 8'd20;
        step(10);

        // simultaneous up+down, then stop+up, then resume to remembered DOWN
        reset_pulse();
        btns(1, 1, 0);
        step(8);
        chk("up_down_same", 2'b10, 1'b1, 1'b0);
        btns(0, 0, 0);
        step(10);
        btns(1, 0, 1);
        step(8);
        chk("stop_beats_up", 2'b11, 1'b0, 1'b0);
        btns(0, 0, 0);
        step(10);
        btn_stop = 1'b1;
        step(8);
        chk("resume_down", 2'b10, 1'b1, 1'b0);
        btn_stop = 1'b0;
        step(10);

        // reset mid-debounce while in DOWN, button released before reset ends
        btn_up = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        chk("rst_mid_down", 2'b00, 1'b0, 1'b1);
        btn_up = 1'b0;
        step(2);
        rst = 1'b1;
        step(12);
        chk("no_spurious", 2'b00, 1'b0, 1'b1);

        // stop in IDLE stays in IDLE
        btn_stop = 1'b1;
        step(8);
        chk("idle_stop", 2'b00, 1'b0, 1'b1);
        btn_stop = 1'b0;
        step(10);
        chk("idle_stop_rel", 2'b00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Control stage directly upstream of the 8-bit up/down counter.
- Turns three raw push-buttons into clean, registered `direction` and `enable` signals for the counter.
- Takes the counter's output back as feedback. In auto-bounce mode it reverses direction at programmable limits, so the counter sweeps between them.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable clocks required before a synchronised button level is accepted (≥1).
- WIDTH, 8: width of `count_in` and the limit inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw asynchronous button: count up.
- btn_down  in  1  raw asynchronous button: count down.
- btn_stop  in  1  raw asynchronous button: pause/resume toggle.
- auto_bounce  in  1  1 = reverse direction at the limits.
- count_in  in  WIDTH  counter's current output (feedback).
- lo_limit  in  WIDTH  lower bounce limit.
- hi_limit  in  WIDTH  upper bounce limit.
- direction  out  1  to counter: 1 = up, 0 = down.
- enable  out  1  to counter: count enable.
- state_out  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst = 0, asynchronous, no clock needed):
  - state IDLE; direction = 1; enable = 0; state_out = 2'b00.
  - All synchroniser, debounce and edge-detect flops cleared to 0.
- Per-button front end:
  - 2-flop synchroniser, then stable counter.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive clocks. Any mismatch shorter than that resets the counter.
  - Press event = one-cycle pulse on a rising edge of the debounced level. A held button gives one event; releases give no event.
- Latency: raw input first sampled high at edge 1 → debounced level high at edge 2+DEBOUNCE_CYCLES → FSM and outputs change at edge 3+DEBOUNCE_CYCLES (edge 7 with default).
- Pulses shorter than DEBOUNCE_CYCLES synchronised clocks produce no event.
- FSM: registered Moore outputs; encoding IDLE = 00, UP = 01, DOWN = 10, HOLD = 11.
  - IDLE: enable = 0, direction = 1.
  - UP: enable = 1, direction = 1.
  - DOWN: enable = 1, direction = 0.
  - HOLD: enable = 0, direction keeps its last value.
- Transitions:
  - up event: IDLE/HOLD/DOWN → UP.
  - down event: IDLE/HOLD/UP → DOWN.
  - stop event:
    - UP or DOWN → HOLD, remembering the previous run state in a 1-bit register.
    - HOLD → the remembered state.
    - IDLE → IDLE.
  - Event in the state it already selects: no change.
- Simultaneous events in one cycle: priority stop > down > up. Lower-priority events that cycle are discarded.
- Auto-bounce (evaluated only when no button event occurs that cycle):
  - UP and count_in ≥ hi_limit → DOWN at the next edge.
  - DOWN and count_in ≤ lo_limit → UP at the next edge.
  - Comparisons are unsigned, full WIDTH.
  - If lo_limit ≥ hi_limit, bounce is disabled, as if auto_bounce = 0.
  - IDLE and HOLD never bounce.
- Counter wrap-around: without auto-bounce, no limiting is applied; the counter wraps on its own.
- Reset mid-operation: outputs return to reset values immediately. If a button is held through reset release, it is re-debounced and produces one event at the same latency as above, measured from release.
- Limit changes take effect the cycle after they are sampled; no internal latching.

Decomposition:
- Package `count_ctrl_pkg`:
  - state typedef/localparams (IDLE, UP, DOWN, HOLD);
  - DIR_UP = 1, DIR_DOWN = 0.
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, press):
  - contains the synchroniser, stable counter and rising-edge detector;
  - instantiated three times.
- FSM and bounce comparators stay in `count_ctrl`.

Test Plan:
1. rst = 0 for 3 cycles with buttons high, then check before any clock edge → state_out = 00, enable = 0, direction = 1. After release, up is held → state_out = 01 at edge 7.
2. From IDLE, btn_up held 10 cycles (DEBOUNCE_CYCLES = 4):
   - state_out = 01, enable = 1, direction = 1 exactly at edge 7;
   - then a 3-cycle btn_down glitch → no change.
3. From IDLE, btn_up and btn_down rise in the same cycle → DOWN (state_out = 10, direction = 0). Then btn_stop and btn_up together → HOLD (11), enable = 0, direction = 0.
4. auto_bounce = 1, lo = 10, hi = 20, state UP:
   - count_in steps 18, 19, 20 → state DOWN, direction = 0 one edge after 20 is seen;
   - count_in steps down to 10 → UP, direction = 1.
   - Repeat with lo = 20, hi = 10 → no bounce.
5. In UP, stop event → HOLD, enable = 0, direction = 1; second stop → UP, enable = 1. In IDLE, stop → stays 00.
6. rst pulled low mid-way through a debounce count and while in DOWN → immediately IDLE/enable = 0. No spurious event on release with the button released.
